// File: rtl/booth_seq_ctrl.sv
// Radix-2 Booth sequencer: counter-driven FSM issuing load/clear/add/sub/shift strobes to an external A:B:Q-1 datapath.
// Optional BOOTH_SEQ_FASTSHIFT_EN: no-op iterations ({M,MP}=00/11) shift directly from EVAL, skipping SHIFT.
module booth_seq_ctrl #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Run,
  input  logic          ClearA_LoadB,
  input  logic          M,
  input  logic          MP,
  output logic          load,
  output logic          clear_acc,
  output logic          add,
  output logic          sub,
  output logic          shift,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] iter
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_EVAL  = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_iter;
  logic [CW-1:0]   w_iter_nxt;
  logic [CW-1:0]   w_iter_inc;
  logic            w_last;
  logic            w_load;
  logic            w_clear;
  logic            w_add;
  logic            w_sub;
  logic            w_shift;
  logic            w_busy;
  logic            w_done;

  // Counter saturates at WIDTH so a stray increment can never wrap it.
  assign w_iter_inc = (r_iter == CW'(WIDTH)) ? r_iter : r_iter + 1'b1;
  assign w_last     = (r_iter == CW'(WIDTH - 1));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_iter  <= '0;
    end else begin
      r_state <= w_next;
      r_iter  <= w_iter_nxt;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_iter_nxt = r_iter;
    w_load     = 1'b0;
    w_clear    = 1'b0;
    w_add      = 1'b0;
    w_sub      = 1'b0;
    w_shift    = 1'b0;
    w_busy     = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_load = ClearA_LoadB & ~Run;
        if (Run) w_next = S_CLR;
      end
      S_CLR: begin
        w_busy     = 1'b1;
        w_clear    = 1'b1;
        w_iter_nxt = '0;
        w_next     = S_EVAL;
      end
      S_EVAL: begin
        w_busy = 1'b1;
        w_sub  = M & ~MP;
        w_add  = ~M & MP;
        w_next = S_SHIFT;
`ifdef BOOTH_SEQ_FASTSHIFT_EN
        if (M == MP) begin
          w_shift    = 1'b1;
          w_iter_nxt = w_iter_inc;
          w_next     = w_last ? S_DONE : S_EVAL;
        end
`endif
      end
      S_SHIFT: begin
        w_busy     = 1'b1;
        w_shift    = 1'b1;
        w_iter_nxt = w_iter_inc;
        w_next     = w_last ? S_DONE : S_EVAL;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_load = ClearA_LoadB & ~Run;
        if (!Run) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are squashed while Reset is high so no strobe leaks in the reset cycle.
  assign load      = w_load  & ~Reset;
  assign clear_acc = w_clear & ~Reset;
  assign add       = w_add   & ~Reset;
  assign sub       = w_sub   & ~Reset;
  assign shift     = w_shift & ~Reset;
  assign busy      = w_busy  & ~Reset;
  assign done      = w_done  & ~Reset;
  assign iter      = Reset ? '0 : r_iter;

endmodule
